// File: rtl/tdm_tx_mux.sv
// tdm_tx_mux: transmit-side TDM multiplexer.
//
// Buffers per-port byte streams in small FIFOs and emits them on one shared
// byte interface. Port k is emitted only in the cycle where the free-running
// 8-bit slot counter equals k, so a receiver running the same counter stays
// phase-aligned. Slots >= NUM_QUEUES are always idle.
//
// Ports:
//   clk                single clock
//   rst                asynchronous, active-low reset
//   port_wr[k]         push strobe for port k
//   port_sop[k]        first-byte-of-packet flag, stored with the byte
//   port_data          port k byte at [k*DATA_WIDTH +: DATA_WIDTH]
//   port_full[k]       FIFO k holds 2^FIFO_DEPTH_LOG2 entries (registered count)
//   port_ovf[k]        sticky drop flag (only with TDM_TX_OVF_EN)
//   output_wire        byte valid in the current slot
//   output_new_packet  sop bit of the emitted byte
//   output_data        emitted byte
//   slot               current slot counter value
//
// Build option: define TDM_TX_OVF_EN to make port_ovf[k] set on a dropped
// push to a full FIFO k (sticky until reset). Undefined, port_ovf is tied 0;
// drop behaviour is the same either way.

module tdm_tx_mux #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_QUEUES      = 12,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_QUEUES-1:0]            port_wr,
  input  logic [NUM_QUEUES-1:0]            port_sop,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] port_data,
  output logic [NUM_QUEUES-1:0]            port_full,
  output logic [NUM_QUEUES-1:0]            port_ovf,
  output logic                             output_wire,
  output logic                             output_new_packet,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic [7:0]                       slot
);

  localparam int W1    = DATA_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  // The output register loaded at this edge is presented during slot+1,
  // so the FIFO popped now is the one owning the next slot.
  logic [7:0]               slot_nxt;
  logic [NUM_QUEUES-1:0]    pop;
  logic [NUM_QUEUES*W1-1:0] head_flat;
  logic                     sel_vld;
  logic [W1-1:0]            sel_word;

  assign slot_nxt = slot + 8'd1;

  // Push handshake: port_wr[k] is a valid with no backpressure wait; the
  // byte is accepted at the edge only if FIFO k is not full before that
  // edge (port_full acts as a registered not-ready). A push to a full FIFO
  // is dropped even if the same edge pops it.
  for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_port
    logic [W1-1:0]              mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       push;

    assign full     = (count == CW'(DEPTH));
    assign push     = port_wr[k] && !full;
    assign pop[k]   = (slot_nxt == 8'(k)) && (count != '0);
    assign head_flat[k*W1 +: W1] = mem[rd_ptr];
    assign port_full[k] = full;

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= {port_sop[k], port_data[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop[k]) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

`ifdef TDM_TX_OVF_EN
    logic ovf;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovf <= 1'b0;
      end else if (port_wr[k] && full) begin
        ovf <= 1'b1;
      end
    end
    assign port_ovf[k] = ovf;
`else
    assign port_ovf[k] = 1'b0;
`endif
  end

  // At most one pop is active per edge (slot_nxt matches a single port).
  always_comb begin
    sel_vld  = 1'b0;
    sel_word = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      if (pop[k]) begin
        sel_vld  = 1'b1;
        sel_word = head_flat[k*W1 +: W1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot              <= 8'd0;
      output_wire       <= 1'b0;
      output_new_packet <= 1'b0;
      output_data       <= '0;
    end else begin
      slot              <= slot_nxt;
      output_wire       <= sel_vld;
      output_new_packet <= sel_word[W1-1];
      output_data       <= sel_word[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_tdm_tx_mux.sv
module tb_tdm_tx_mux;

  localparam int NQ    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

`ifdef TDM_TX_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NQ-1:0]     port_wr;
  logic [NQ-1:0]     port_sop;
  logic [NQ*DW-1:0]  port_data;
  logic [NQ-1:0]     port_full;
  logic [NQ-1:0]     port_ovf;
  logic              output_wire;
  logic              output_new_packet;
  logic [DW-1:0]     output_data;
  logic [7:0]        slot;

  tdm_tx_mux #(
    .DATA_WIDTH(DW),
    .NUM_QUEUES(NQ),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .port_wr(port_wr),
    .port_sop(port_sop),
    .port_data(port_data),
    .port_full(port_full),
    .port_ovf(port_ovf),
    .output_wire(output_wire),
    .output_new_packet(output_new_packet),
    .output_data(output_data),
    .slot(slot)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Per-port queue of {sop, data} bytes accepted and not yet emitted.
  logic [DW:0]   mq [NQ][$];
  logic [NQ-1:0] m_ovf;
  logic [7:0]    m_slot;
  logic          e_wire;
  logic          e_sop;
  logic [DW-1:0] e_data;

  typedef struct {
    int         port;
    int         push_cyc;
    logic [7:0] data;
    logic       sop;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NQ-1:0] m_full();
    logic [NQ-1:0] f;
    for (int k = 0; k < NQ; k++) f[k] = (mq[k].size() == DEPTH);
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NQ; k++) mq[k].delete();
    m_ovf  = '0;
    m_slot = 8'd0;
    e_wire = 1'b0;
    e_sop  = 1'b0;
    e_data = '0;
    cyc    = 0;
  endtask

  task automatic check_outputs();
    chk("slot", 32'(slot), 32'(m_slot));
    chk("wire", 32'(output_wire), 32'(e_wire));
    chk("new_packet", 32'(output_new_packet), 32'(e_sop));
    chk("data", 32'(output_data), 32'(e_data));
    chk("full", 32'(port_full), 32'(m_full()));
    chk("ovf", 32'(port_ovf), 32'(m_ovf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    port_wr   = '0;
    port_sop  = '0;
    port_data = '0;
  endtask

  // Advance one clock with the currently driven inputs. The model decides
  // what the edge does (accept/drop, which slot is served next), then the
  // DUT is sampled 1 ns after the edge.
  task automatic cycle();
    logic [NQ-1:0] acc;
    logic [DW:0]   w;
    int            n;
    for (int k = 0; k < NQ; k++) begin
      acc[k] = port_wr[k] && (mq[k].size() < DEPTH);
      if (port_wr[k] && !acc[k] && OVF_EN) m_ovf[k] = 1'b1;
    end
    n = (int'(m_slot) + 1) % 256;
    if (n < NQ && mq[n].size() > 0) begin
      w      = mq[n].pop_front();
      e_wire = 1'b1;
      e_sop  = w[DW];
      e_data = w[DW-1:0];
    end else begin
      e_wire = 1'b0;
      e_sop  = 1'b0;
      e_data = '0;
    end
    for (int k = 0; k < NQ; k++) begin
      if (acc[k]) mq[k].push_back({port_sop[k], port_data[k*DW +: DW]});
    end
    m_slot = m_slot + 8'd1;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) cycle();
  endtask

  task automatic push1(input int p, input logic [7:0] d, input logic s);
    clear_in();
    port_wr[p]          = 1'b1;
    port_sop[p]         = s;
    port_data[p*DW +: DW] = d;
    cycle();
    clear_in();
  endtask

  // Asserts reset asynchronously (between edges), checks the outputs clear
  // at once, then releases so the following cycle is cycle 0 / slot 0.
  task automatic do_reset();
    clear_in();
    rst = 1'b0;
    #2;
    chk("rst_wire", 32'(output_wire), 32'd0);
    chk("rst_new_packet", 32'(output_new_packet), 32'd0);
    chk("rst_data", 32'(output_data), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    model_clear();
    #1;
    rst = 1'b1;
    check_outputs();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Single-push latency vectors: expected emission cycle from the slot rule.
    vecs[0] = '{port: 3,  push_cyc: 0,   data: 8'hA5, sop: 1'b1, exp_cyc: 3};
    vecs[1] = '{port: 0,  push_cyc: 0,   data: 8'h5A, sop: 1'b0, exp_cyc: 256};
    vecs[2] = '{port: 11, push_cyc: 9,   data: 8'h3C, sop: 1'b1, exp_cyc: 11};
    vecs[3] = '{port: 11, push_cyc: 10,  data: 8'h77, sop: 1'b0, exp_cyc: 267};
    vecs[4] = '{port: 5,  push_cyc: 200, data: 8'h99, sop: 1'b1, exp_cyc: 261};
    vecs[5] = '{port: 1,  push_cyc: 255, data: 8'h42, sop: 1'b0, exp_cyc: 257};
    vecs[6] = '{port: 0,  push_cyc: 254, data: 8'hC3, sop: 1'b1, exp_cyc: 256};
    vecs[7] = '{port: 0,  push_cyc: 255, data: 8'hE1, sop: 1'b0, exp_cyc: 512};

    rst = 1'b0;
    clear_in();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle run: slot wraps at cycle 256, everything else stays zero.
    idle(600);

    // Table-driven latency checks.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      while (cyc < vecs[i].push_cyc) cycle();
      push1(vecs[i].port, vecs[i].data, vecs[i].sop);
      while (cyc < vecs[i].exp_cyc) cycle();
      chk("vec_wire", 32'(output_wire), 32'd1);
      chk("vec_new_packet", 32'(output_new_packet), 32'(vecs[i].sop));
      chk("vec_data", 32'(output_data), 32'(vecs[i].data));
      chk("vec_slot", 32'(slot), 32'(vecs[i].port));
    end

    // Two ports pushed in the same cycle.
    do_reset();
    clear_in();
    port_wr[1] = 1'b1;  port_data[1*DW +: DW]  = 8'h22;
    port_wr[11] = 1'b1; port_data[11*DW +: DW] = 8'h11;
    cycle();
    clear_in();
    while (cyc < 11) cycle();
    chk("two_p11", 32'(output_data), 32'h11);
    while (cyc < 257) cycle();
    chk("two_p1", 32'(output_data), 32'h22);
    idle(300);

    // Fill port 5 to full, overflow it, then drain one byte per frame.
    do_reset();
    idle(6);
    for (int i = 0; i < 16; i++) push1(5, 8'(i), (i == 0));
    chk("full_after16", 32'(port_full[5]), 32'd1);
    push1(5, 8'hFF, 1'b0);
    chk("ovf5", 32'(port_ovf[5]), 32'(OVF_EN));
    chk("full_hold", 32'(port_full[5]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      while (cyc < 256 * (i + 1) + 5) cycle();
      chk("fill_wire", 32'(output_wire), 32'd1);
      chk("fill_data", 32'(output_data), 32'(i));
      if (i == 0) chk("full_clear", 32'(port_full[5]), 32'd0);
    end
    idle(300);

    // Reset mid-frame with bytes queued on port 7.
    do_reset();
    for (int i = 0; i < 4; i++) push1(7, 8'(8'h70 + i), (i == 0));
    while (cyc < 7) cycle();
    chk("pre_rst_wire", 32'(output_wire), 32'd1);
    chk("pre_rst_data", 32'(output_data), 32'h70);
    do_reset();
    idle(512);

    // Randomized traffic against the model; overflow is likely on busy ports.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < NQ; k++) begin
        port_wr[k]          = ($urandom_range(0, 9) == 0);
        port_sop[k]         = 1'($urandom_range(0, 1));
        port_data[k*DW +: DW] = 8'($urandom_range(0, 255));
      end
      cycle();
    end
    idle(600);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_tx_mux.md
# tdm_tx_mux

Transmit-side TDM multiplexer that drives the shared byte stream consumed by the 12-port switch top level. It buffers per-port byte streams in small FIFOs and emits them on a single serial byte interface: `output_wire`, `output_new_packet` and `output_data`. Port k is emitted only in the cycle where the free-running 8-bit slot counter equals k, so the transmitter's slot counter stays phase-aligned with the receiver's `input_sel` counter. The block sits upstream of the switch, in the traffic source or test harness.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width
- NUM_QUEUES, 12, number of ports/slots; must be ≤ 256
- FIFO_DEPTH_LOG2, 4, per-port FIFO depth is 2^FIFO_DEPTH_LOG2 (16)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-low
- port_wr  in  NUM_QUEUES  push strobe, one bit per port
- port_sop  in  NUM_QUEUES  first byte of packet, stored with the byte
- port_data  in  NUM_QUEUES*DATA_WIDTH  port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- port_full  out  NUM_QUEUES  FIFO k holds 2^FIFO_DEPTH_LOG2 entries
- port_ovf  out  NUM_QUEUES  sticky drop flag (see Configuration)
- output_wire  out  1  byte valid in current slot
- output_new_packet  out  1  sop bit of emitted byte
- output_data  out  DATA_WIDTH  emitted byte
- slot  out  8  current slot counter value

## Operation
- Slot counter:
  - 8 bits; reset value 0.
  - Increments every cycle and wraps 255→0.
  - One frame is 256 cycles. Slots ≥ NUM_QUEUES are always idle.
- Per-port FIFO:
  - Width DATA_WIDTH+1 (data plus sop bit); read/write pointers plus an occupancy count, all registered.
  - Push: port_wr[k]=1 and FIFO k not full. The full state is evaluated before the edge.
  - Push while full: the byte is dropped, even if a pop happens at the same edge.
  - Push and pop at the same edge on a non-full FIFO: both take effect and the count is unchanged.
  - port_full[k] is decoded from registered count only. There is no combinational path from any input.
- Output load, at each edge:
  - Let n = slot+1 mod 256.
  - If n < NUM_QUEUES and FIFO n is non-empty: pop the head and load output_wire=1, output_new_packet=sop, output_data=data.
  - Otherwise load output_wire=0, output_new_packet=0, output_data=0.
- The block sends bytes in order within each port. It does not interpret packet structure: sop is carried through unchanged.
- Reset (asynchronous, at any time):
  - slot=0; all FIFOs empty with pointers and count at 0.
  - output_wire=0, output_new_packet=0, output_data=0.
  - port_full=0, port_ovf=0.
  - Queued bytes are discarded.

## Timing
- All outputs are registered.
- In every cycle where slot==k, the outputs carry port k's byte or idle zeros.
- Minimum latency:
  - A byte pushed to empty FIFO k in a cycle with slot==k−2 (mod 256) appears in the cycle with slot==k.
  - This is 2 cycles.
  - A push any later in the frame waits for the next frame.
- Maximum latency for the head byte: 257 cycles.
- Throughput: one byte per port per 256-cycle frame.
- First cycle after reset release: slot=0 and the outputs are idle. Port 0's first emission is at cycle 256 (slot 0 of frame 1).
- port_full:
  - Asserts the cycle after the filling push.
  - Deasserts the cycle after the first pop.

## Configuration
- Macro: `TDM_TX_OVF_EN`.
- Defined: port_ovf[k] is set at the edge where a push to full FIFO k is dropped. It stays set until reset.
- Undefined: the overflow logic is compiled out and port_ovf is tied to 0. Drop behaviour is unchanged.

## Test plan
- Reset, then run 600 cycles with no pushes:
  - slot counts 0..255 and wraps to 0 at cycle 256.
  - All outputs stay 0; port_full=0, port_ovf=0.
- Push port 3 with data 0xA5, sop=1 in cycle 0 (slot 0):
  - Cycle 3: output_wire=1, output_new_packet=1, output_data=0xA5.
  - All other cycles idle.
- Push port 0 with data 0x5A, sop=0 in cycle 0:
  - First emission at cycle 256: wire=1, new_packet=0, data=0x5A.
- Push 16 bytes 0x00..0x0F to port 5, then push 0xFF:
  - port_full[5]=1 after the 16th push.
  - 0xFF is dropped and port_ovf[5]=1 with `TDM_TX_OVF_EN` defined (0 without it).
  - Bytes 0x00..0x0F emerge in order at slot 5 of consecutive frames.
  - port_full[5] clears after the first pop.
- Push port 1 with 0x22 and port 11 with 0x11 in the same cycle:
  - 0x22 appears at slot 1 and 0x11 at slot 11.
  - Slots 12..255 stay idle.
- With 4 bytes queued on port 7, assert rst mid-frame:
  - Outputs go to 0 immediately.
  - After release, slot restarts at 0 and no stale byte appears on slot 7 in the next 2 frames.
